// File: rtl/program_memory_pkg.sv
// Shared definitions for the program memory and its CPU neighbour:
// bus widths, loader/sequencer state encoding and a sizing helper.
package program_memory_pkg;

  localparam int PM_ADDR_WIDTH  = 12;
  localparam int PM_DATA_WIDTH  = 8;
  localparam int PM_HOLD_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } pm_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int pm_cnt_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/program_memory_ram.sv
// Program storage: DEPTH x DATA_WIDTH array, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module pm_ram
  import program_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = PM_ADDR_WIDTH,
  parameter int DATA_WIDTH = PM_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Loader write port.
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/program_memory.sv
// CPU-side program memory: zero-wait combinational fetch onto D_BUS, plus a
// valid/ready byte loader that holds the CPU in reset until the image is in.
module program_memory
  import program_memory_pkg::*;
#(
  parameter int ADDR_WIDTH  = PM_ADDR_WIDTH,
  parameter int DATA_WIDTH  = PM_DATA_WIDTH,
  parameter int HOLD_CYCLES = PM_HOLD_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] D_BUS,
  output logic                  cpu_reset,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic [ADDR_WIDTH:0]   ld_count,
  output logic                  running
);

  localparam int HCW = pm_cnt_width(HOLD_CYCLES);

  pm_state_e             r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [HCW-1:0]        r_hold_cnt;
  logic [ADDR_WIDTH:0]   r_ld_count;
  logic                  r_ld_ready;
  logic                  r_cpu_reset;
  logic                  r_running;

  logic                  w_xfer;
  logic                  w_we;
  logic                  w_last_addr;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_xfer      = (r_state == ST_LOAD) & ld_valid & r_ld_ready;
  // A restart or reset in the same cycle drops the offered byte.
  assign w_we        = w_xfer & ~ld_start & ~reset;
  assign w_last_addr = (r_wr_ptr == {ADDR_WIDTH{1'b1}});

  pm_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clock   (clock),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (ld_data),
    .i_raddr (address),
    .o_rdata (w_rdata)
  );

  // Loader/run sequencer with registered control outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= {ADDR_WIDTH{1'b0}};
      r_hold_cnt  <= {HCW{1'b0}};
      r_ld_count  <= {(ADDR_WIDTH+1){1'b0}};
      r_ld_ready  <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_running   <= 1'b0;
    end else begin
      // cpu_reset only drops one cycle after RUN is entered, but rises at once on leaving it.
      r_cpu_reset <= 1'b1;
      r_running   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ld_start) begin
            r_state    <= ST_LOAD;
            r_wr_ptr   <= {ADDR_WIDTH{1'b0}};
            r_ld_count <= {(ADDR_WIDTH+1){1'b0}};
            r_ld_ready <= 1'b1;
          end else begin
            r_ld_ready <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (ld_start) begin
            r_wr_ptr   <= {ADDR_WIDTH{1'b0}};
            r_ld_count <= {(ADDR_WIDTH+1){1'b0}};
            r_ld_ready <= 1'b1;
          end else if (w_xfer) begin
            r_wr_ptr   <= r_wr_ptr + ADDR_WIDTH'(1);
            r_ld_count <= r_ld_count + (ADDR_WIDTH+1)'(1);
            if (ld_last || w_last_addr) begin
              r_state    <= ST_HOLD;
              r_hold_cnt <= {HCW{1'b0}};
              r_ld_ready <= 1'b0;
            end else begin
              r_ld_ready <= 1'b1;
            end
          end else begin
            r_ld_ready <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (ld_start) begin
            r_state    <= ST_LOAD;
            r_wr_ptr   <= {ADDR_WIDTH{1'b0}};
            r_ld_count <= {(ADDR_WIDTH+1){1'b0}};
            r_ld_ready <= 1'b1;
          end else if (r_hold_cnt == HCW'(HOLD_CYCLES - 1)) begin
            r_state    <= ST_RUN;
            r_ld_ready <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HCW'(1);
            r_ld_ready <= 1'b0;
          end
        end
        ST_RUN: begin
          if (ld_start) begin
            r_state    <= ST_LOAD;
            r_wr_ptr   <= {ADDR_WIDTH{1'b0}};
            r_ld_count <= {(ADDR_WIDTH+1){1'b0}};
            r_ld_ready <= 1'b1;
          end else begin
            r_cpu_reset <= 1'b0;
            r_running   <= 1'b1;
            r_ld_ready  <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_ld_ready <= 1'b0;
        end
      endcase
    end
  end

  // Fetch data is only presented while the program is live.
  always_comb begin
    D_BUS = {DATA_WIDTH{1'b0}};
    if (r_state == ST_RUN) begin
      D_BUS = w_rdata;
    end else begin
      D_BUS = {DATA_WIDTH{1'b0}};
    end
  end

  assign cpu_reset = r_cpu_reset;
  assign running   = r_running;
  assign ld_ready  = r_ld_ready;
  assign ld_count  = r_ld_count;

endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory: a timeline model of load/hold/run checked
// every cycle, plus hand-computed expectations at the key points.
module tb_program_memory;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int H     = 2;
  localparam int DEPTH = 4096;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] D_BUS;
  logic          cpu_reset;
  logic          ld_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_last = 1'b0;
  logic          ld_ready;
  logic [AW:0]   ld_count;
  logic          running;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  program_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOLD_CYCLES(H)) dut (
    .clock     (clock),
    .reset     (reset),
    .address   (address),
    .D_BUS     (D_BUS),
    .cpu_reset (cpu_reset),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .ld_count  (ld_count),
    .running   (running)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: which phase we are in, expressed as remaining hold time and time spent running.
  logic [DW-1:0] m_mem [DEPTH];
  bit m_init    = 1'b0;
  bit m_loading = 1'b0;
  int m_ptr     = 0;
  int m_count   = 0;
  int m_hold    = 0;
  int m_run     = -1;

  always @(posedge clock) begin
    if (reset) begin
      m_init    <= 1'b1;
      m_loading <= 1'b0;
      m_count   <= 0;
      m_hold    <= 0;
      m_run     <= -1;
    end else if (ld_start) begin
      m_loading <= 1'b1;
      m_ptr     <= 0;
      m_count   <= 0;
      m_hold    <= 0;
      m_run     <= -1;
    end else if (m_loading) begin
      if (ld_valid) begin
        m_mem[m_ptr] <= ld_data;
        m_ptr        <= m_ptr + 1;
        m_count      <= m_count + 1;
        if (ld_last || (m_count + 1 == DEPTH)) begin
          m_loading <= 1'b0;
          m_hold    <= H;
        end
      end
    end else if (m_hold > 0) begin
      m_hold <= m_hold - 1;
      if (m_hold == 1) m_run <= 0;
    end else if (m_run >= 0 && m_run < 2) begin
      m_run <= m_run + 1;
    end
  end

  always @(negedge clock) begin
    if (m_init) begin
      chk("ld_ready", ld_ready, m_loading);
      chk("cpu_reset", cpu_reset, (m_run >= 1) ? 0 : 1);
      chk("running", running, (m_run >= 1) ? 1 : 0);
      chk("ld_count", ld_count, m_count);
      chk("D_BUS", D_BUS, (m_run >= 0) ? m_mem[address] : 8'h00);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (cpu_reset !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    chk("run_timeout", (n < 50) ? 1 : 0, 1);
  endtask

  task automatic rd(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    address = a;
    #1;
    chk(nm, D_BUS, exp);
  endtask

  initial begin
    int n;
    tick();
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("idle_cpu_reset", cpu_reset, 1);
    chk("idle_ld_ready", ld_ready, 0);
    chk("idle_dbus", D_BUS, 8'h00);
    chk("idle_running", running, 0);

    // Basic three-byte load.
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data = 8'hA1; tick();
    ld_data = 8'hB2; tick();
    ld_data = 8'hC3; ld_last = 1'b1; tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("abc_count", ld_count, 3);
    n = 0;
    while (cpu_reset === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("cpu_reset_fall", n, H + 1);
    rd("abc_a0", 12'h000, 8'hA1);
    rd("abc_a1", 12'h001, 8'hB2);
    rd("abc_a2", 12'h002, 8'hC3);

    // Valid offered early and with gaps.
    ld_valid = 1'b1; ld_data = 8'h77; ld_start = 1'b1; tick(); ld_start = 1'b0;
    ld_data = 8'h11; tick();
    ld_valid = 1'b0; tick();
    ld_valid = 1'b1; ld_data = 8'h22; tick();
    ld_valid = 1'b0; tick(); tick();
    ld_valid = 1'b1; ld_data = 8'h33; ld_last = 1'b1; tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("gap_count", ld_count, 3);
    wait_run();
    rd("gap_a0", 12'h000, 8'h11);
    rd("gap_a1", 12'h001, 8'h22);
    rd("gap_a2", 12'h002, 8'h33);

    // Full-depth load with no last marker.
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    ld_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ld_data = i[7:0];
      tick();
    end
    ld_valid = 1'b0;
    chk("full_count", ld_count, 4096);
    chk("full_ready", ld_ready, 0);
    wait_run();
    rd("full_fff", 12'hFFF, 8'hFF);
    rd("full_002", 12'h002, 8'h02);
    rd("full_080", 12'h080, 8'h80);

    // Reload from RUN.
    address = 12'h000;
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    chk("rel_cpu_reset", cpu_reset, 1);
    chk("rel_dbus", D_BUS, 8'h00);
    chk("rel_running", running, 0);
    ld_valid = 1'b1; ld_data = 8'h55; ld_last = 1'b1; tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    wait_run();
    rd("rel_a0", 12'h000, 8'h55);
    rd("rel_a1", 12'h001, 8'h01);

    // Restart colliding with a transfer, then reset mid-load.
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 8'hAA; tick();
    chk("col_count1", ld_count, 1);
    ld_data = 8'hBB; ld_start = 1'b1; tick(); ld_start = 1'b0;
    chk("col_count0", ld_count, 0);
    ld_data = 8'hCC; tick();
    chk("col_count1b", ld_count, 1);
    ld_data = 8'hDD; reset = 1'b1; tick();
    reset = 1'b0; ld_valid = 1'b0;
    chk("rst_count", ld_count, 0);
    chk("rst_ready", ld_ready, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    tick(); tick();
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 8'hEE; ld_last = 1'b1; tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    wait_run();
    rd("fin_a0", 12'h000, 8'hEE);
    rd("fin_a1", 12'h001, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
